// File: rtl/branch_sequencer.sv
// Fetch-PC owner and branch-unit sequencer: one bu_en pulse per accepted branch/jump,
// then resume sequential fetch or redirect + flush. Optional macro BRANCH_SEQ_STATS_EN adds resolve counters.
module branch_sequencer #(
    parameter int unsigned       ADDR_W       = 10,
    parameter logic [ADDR_W-1:0] RESET_PC     = 10'd0,
    parameter int unsigned       FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              insn_valid,
    input  logic              is_branch,
    input  logic              is_jump,
    input  logic [2:0]        funct3,
    input  logic [19:0]       imm,
    input  logic [31:0]       op0,
    input  logic [31:0]       op1,
    input  logic [ADDR_W-1:0] insn_pc,
    input  logic              bu_branch,
    input  logic [ADDR_W-1:0] bu_target,
    output logic              bu_en,
    output logic              bu_b,
    output logic              bu_j,
    output logic [2:0]        bu_funct3,
    output logic [19:0]       bu_imm,
    output logic [31:0]       bu_op0,
    output logic [31:0]       bu_op1,
    output logic [ADDR_W-1:0] bu_addr,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              flush,
    output logic              redirect
`ifdef BRANCH_SEQ_STATS_EN
    ,
    output logic [15:0]       stat_taken,
    output logic [15:0]       stat_not_taken
`endif
);

    typedef enum logic [2:0] {
        S_RUN,
        S_ISSUE,
        S_WAIT,
        S_RESOLVE,
        S_FLUSH
    } state_t;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              busy_q, busy_d;
    logic              flush_q, flush_d;
    logic              redirect_q, redirect_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              bu_en_q, bu_en_d;
    logic              bu_b_q, bu_b_d;
    logic              bu_j_q, bu_j_d;
    logic [2:0]        bu_funct3_q, bu_funct3_d;
    logic [19:0]       bu_imm_q, bu_imm_d;
    logic [31:0]       bu_op0_q, bu_op0_d;
    logic [31:0]       bu_op1_q, bu_op1_d;
    logic [ADDR_W-1:0] bu_addr_q, bu_addr_d;
`ifdef BRANCH_SEQ_STATS_EN
    logic [15:0]       stat_taken_q, stat_taken_d;
    logic [15:0]       stat_not_taken_q, stat_not_taken_d;
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        busy_d      = 1'b0;
        flush_d     = 1'b0;
        redirect_d  = 1'b0;
        cnt_d       = cnt_q;
        bu_en_d     = 1'b0;
        bu_b_d      = bu_b_q;
        bu_j_d      = bu_j_q;
        bu_funct3_d = bu_funct3_q;
        bu_imm_d    = bu_imm_q;
        bu_op0_d    = bu_op0_q;
        bu_op1_d    = bu_op1_q;
        bu_addr_d   = bu_addr_q;
`ifdef BRANCH_SEQ_STATS_EN
        stat_taken_d     = stat_taken_q;
        stat_not_taken_d = stat_not_taken_q;
`endif
        case (state_q)
            S_RUN: begin
                if (!stall) begin
                    if (insn_valid && (is_branch || is_jump)) begin
                        bu_b_d      = is_branch & ~is_jump;
                        bu_j_d      = is_jump;
                        bu_funct3_d = funct3;
                        bu_imm_d    = imm;
                        bu_op0_d    = op0;
                        bu_op1_d    = op1;
                        bu_addr_d   = insn_pc;
                        bu_en_d     = 1'b1;
                        busy_d      = 1'b1;
                        state_d     = S_ISSUE;
                    end else begin
                        pc_d = pc_q + ADDR_W'(1);
                    end
                end
            end
            S_ISSUE: begin
                busy_d  = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                busy_d  = 1'b1;
                state_d = S_RESOLVE;
            end
            S_RESOLVE: begin
                if (bu_branch) begin
                    pc_d       = bu_target;
                    redirect_d = 1'b1;
                    flush_d    = 1'b1;
                    cnt_d      = FLUSH_INIT;
                    state_d    = S_FLUSH;
`ifdef BRANCH_SEQ_STATS_EN
                    if (stat_taken_q != 16'hFFFF) stat_taken_d = stat_taken_q + 16'd1;
`endif
                end else begin
                    pc_d    = bu_addr_q + ADDR_W'(1);
                    state_d = S_RUN;
`ifdef BRANCH_SEQ_STATS_EN
                    if (stat_not_taken_q != 16'hFFFF) stat_not_taken_d = stat_not_taken_q + 16'd1;
`endif
                end
            end
            S_FLUSH: begin
                if (!stall) pc_d = pc_q + ADDR_W'(1);
                // flush is registered, so it stays high while the counter still has cycles left
                if (cnt_q == 3'd0) begin
                    state_d = S_RUN;
                end else begin
                    cnt_d   = cnt_q - 3'd1;
                    flush_d = 1'b1;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_RUN;
            pc_q        <= RESET_PC;
            busy_q      <= 1'b0;
            flush_q     <= 1'b0;
            redirect_q  <= 1'b0;
            cnt_q       <= 3'd0;
            bu_en_q     <= 1'b0;
            bu_b_q      <= 1'b0;
            bu_j_q      <= 1'b0;
            bu_funct3_q <= 3'd0;
            bu_imm_q    <= 20'd0;
            bu_op0_q    <= 32'd0;
            bu_op1_q    <= 32'd0;
            bu_addr_q   <= '0;
`ifdef BRANCH_SEQ_STATS_EN
            stat_taken_q     <= 16'd0;
            stat_not_taken_q <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            busy_q      <= busy_d;
            flush_q     <= flush_d;
            redirect_q  <= redirect_d;
            cnt_q       <= cnt_d;
            bu_en_q     <= bu_en_d;
            bu_b_q      <= bu_b_d;
            bu_j_q      <= bu_j_d;
            bu_funct3_q <= bu_funct3_d;
            bu_imm_q    <= bu_imm_d;
            bu_op0_q    <= bu_op0_d;
            bu_op1_q    <= bu_op1_d;
            bu_addr_q   <= bu_addr_d;
`ifdef BRANCH_SEQ_STATS_EN
            stat_taken_q     <= stat_taken_d;
            stat_not_taken_q <= stat_not_taken_d;
`endif
        end
    end

    assign bu_en     = bu_en_q;
    assign bu_b      = bu_b_q;
    assign bu_j      = bu_j_q;
    assign bu_funct3 = bu_funct3_q;
    assign bu_imm    = bu_imm_q;
    assign bu_op0    = bu_op0_q;
    assign bu_op1    = bu_op1_q;
    assign bu_addr   = bu_addr_q;
    assign pc        = pc_q;
    assign busy      = busy_q;
    assign flush     = flush_q;
    assign redirect  = redirect_q;
`ifdef BRANCH_SEQ_STATS_EN
    assign stat_taken     = stat_taken_q;
    assign stat_not_taken = stat_not_taken_q;
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Scoreboard bench for branch_sequencer: transaction model feeds expected issues/resolutions,
// a negedge monitor pops and compares them; per-cycle pc/busy/flush checks ride along.
module tb_branch_sequencer;

    localparam int          FLUSH_N = 2;
    localparam logic [9:0]  RST_PC  = 10'd5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, insn_valid = 1'b0, is_branch = 1'b0, is_jump = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [19:0] imm = '0;
    logic [31:0] op0 = '0, op1 = '0;
    logic [9:0]  insn_pc = '0;
    logic        bu_branch = 1'b0;
    logic [9:0]  bu_target = '0;
    logic        bu_en, bu_b, bu_j;
    logic [2:0]  bu_funct3;
    logic [19:0] bu_imm;
    logic [31:0] bu_op0, bu_op1;
    logic [9:0]  bu_addr, pc;
    logic        busy, flush, redirect;
`ifdef BRANCH_SEQ_STATS_EN
    logic [15:0] stat_taken, stat_not_taken;
`endif

    always #5 clk = ~clk;

    branch_sequencer #(.ADDR_W(10), .RESET_PC(RST_PC), .FLUSH_CYCLES(FLUSH_N)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .insn_valid(insn_valid),
        .is_branch(is_branch), .is_jump(is_jump), .funct3(funct3), .imm(imm),
        .op0(op0), .op1(op1), .insn_pc(insn_pc), .bu_branch(bu_branch), .bu_target(bu_target),
        .bu_en(bu_en), .bu_b(bu_b), .bu_j(bu_j), .bu_funct3(bu_funct3), .bu_imm(bu_imm),
        .bu_op0(bu_op0), .bu_op1(bu_op1), .bu_addr(bu_addr), .pc(pc), .busy(busy),
        .flush(flush), .redirect(redirect)
`ifdef BRANCH_SEQ_STATS_EN
        , .stat_taken(stat_taken), .stat_not_taken(stat_not_taken)
`endif
    );

    typedef struct {
        logic        b, j;
        logic [2:0]  f3;
        logic [19:0] im;
        logic [31:0] a0, a1;
        logic [9:0]  addr;
    } iss_t;

    typedef struct {
        logic [9:0] pc;
        logic       redir;
    } res_t;

    iss_t exp_iss[$];
    res_t exp_res[$];

    int n_tests = 0;
    int n_fail  = 0;
    logic skip_fall = 1'b0;

    // transaction-level model: cycles left in the branch window and in the flush window
    logic [9:0] m_pc = RST_PC;
    int         m_busy_left = 0;
    int         m_flush_left = 0;
    logic       m_redirect = 1'b0;
    logic [9:0] m_addr = '0;
    logic       m_taken = 1'b0;
    logic [9:0] m_target = '0;
    int         m_cnt_t = 0, m_cnt_nt = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic step(input logic rst, input logic st, input logic v, input logic b, input logic j,
                        input logic [2:0] f3, input logic [19:0] im, input logic [31:0] a0,
                        input logic [31:0] a1, input logic [9:0] ip, input logic tk, input logic [9:0] tg);
        iss_t e;
        rst_n = rst; stall = st; insn_valid = v; is_branch = b; is_jump = j;
        funct3 = f3; imm = im; op0 = a0; op1 = a1; insn_pc = ip;
        m_redirect = 1'b0;
        if (!rst) begin
            if (m_busy_left > 0) skip_fall = 1'b1;
            m_pc = RST_PC; m_busy_left = 0; m_flush_left = 0;
            m_cnt_t = 0; m_cnt_nt = 0;
        end else if (m_busy_left > 0) begin
            if (m_busy_left == 1) begin
                if (m_taken) begin
                    m_pc = m_target; m_flush_left = FLUSH_N; m_redirect = 1'b1; m_cnt_t++;
                end else begin
                    m_pc = m_addr + 10'd1; m_cnt_nt++;
                end
                exp_res.push_back('{pc: m_pc, redir: m_redirect});
            end
            m_busy_left--;
        end else if (m_flush_left > 0) begin
            if (!st) m_pc = m_pc + 10'd1;
            m_flush_left--;
        end else if (!st && v && (b || j)) begin
            e.b = b & ~j; e.j = j; e.f3 = f3; e.im = im; e.a0 = a0; e.a1 = a1; e.addr = ip;
            exp_iss.push_back(e);
            m_addr = ip; m_busy_left = 3; m_taken = tk; m_target = tg;
            bu_branch = tk; bu_target = tg;
        end else if (!st) begin
            m_pc = m_pc + 10'd1;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("pc", pc, m_pc);
        check("busy", busy, m_busy_left > 0);
        check("bu_en", bu_en, m_busy_left == 3);
        check("flush", flush, m_flush_left > 0);
        check("redirect", redirect, m_redirect);
    endtask

    task automatic idle(input logic st);
        step(1'b1, st, 1'b0, 1'b0, 1'b0, 3'd0, 20'd0, 32'd0, 32'd0, 10'd0, m_taken, m_target);
    endtask

    task automatic br(input logic b, input logic j, input logic [2:0] f3, input logic [31:0] a0,
                      input logic [31:0] a1, input logic [9:0] ip, input logic tk, input logic [9:0] tg);
        step(1'b1, 1'b0, 1'b1, b, j, f3, 20'h00abc, a0, a1, ip, tk, tg);
    endtask

    // monitor: compares DUT transactions against the scoreboard queues
    logic bu_en_prev = 1'b0;
    logic busy_prev  = 1'b0;
    initial begin
        iss_t e;
        res_t r;
        forever begin
            @(negedge clk);
            if (bu_en === 1'b1) begin
                check("bu_en_gap", bu_en_prev, 1'b0);
                if (exp_iss.size() == 0) begin
                    check("unexpected_bu_en", 1'b1, 1'b0);
                end else begin
                    e = exp_iss.pop_front();
                    check("bu_b", bu_b, e.b);
                    check("bu_j", bu_j, e.j);
                    check("bu_funct3", bu_funct3, e.f3);
                    check("bu_imm", bu_imm, e.im);
                    check("bu_op0", bu_op0, e.a0);
                    check("bu_op1", bu_op1, e.a1);
                    check("bu_addr", bu_addr, e.addr);
                end
            end
            if (busy_prev === 1'b1 && busy === 1'b0) begin
                if (skip_fall) begin
                    skip_fall = 1'b0;
                    check("abort_pc", pc, RST_PC);
                    check("abort_redirect", redirect, 1'b0);
                end else if (exp_res.size() == 0) begin
                    check("unexpected_resolve", 1'b1, 1'b0);
                end else begin
                    r = exp_res.pop_front();
                    check("res_pc", pc, r.pc);
                    check("res_redirect", redirect, r.redir);
                    check("res_flush", flush, r.redir);
                end
            end
            bu_en_prev = (bu_en === 1'b1);
            busy_prev  = (busy === 1'b1);
        end
    end

    initial begin
        logic [1:0] cls;
        @(posedge clk);
        #1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 20'd0, 32'd0, 32'd0, 10'd0, 1'b0, 10'd0);
        repeat (3) idle(1'b0);

        // BEQ taken to 40
        br(1'b1, 1'b0, 3'd0, 32'h1234, 32'h1234, 10'd20, 1'b1, 10'd40);
        repeat (6) idle(1'b0);
        // BNE not taken
        br(1'b1, 1'b0, 3'd1, 32'h1234, 32'h1234, 10'd20, 1'b0, 10'd77);
        repeat (4) idle(1'b0);

        // wrap through 1023 -> 0, then not-taken branch at 1023
        br(1'b0, 1'b1, 3'd0, 32'd1, 32'd2, 10'd300, 1'b1, 10'd1021);
        repeat (6) idle(1'b0);
        br(1'b1, 1'b0, 3'd4, 32'd9, 32'd3, 10'd1023, 1'b0, 10'd12);
        repeat (4) idle(1'b0);

        // branches offered during flush and under stall are ignored
        br(1'b1, 1'b1, 3'd5, 32'hdead, 32'hbeef, 10'd50, 1'b1, 10'd100);
        repeat (3) idle(1'b0);
        br(1'b1, 1'b0, 3'd0, 32'd7, 32'd7, 10'd60, 1'b1, 10'd200);
        br(1'b0, 1'b1, 3'd0, 32'd7, 32'd7, 10'd61, 1'b1, 10'd201);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 20'd1, 32'd1, 32'd1, 10'd62, 1'b1, 10'd202);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 20'd1, 32'd1, 32'd1, 10'd63, 1'b1, 10'd203);
        idle(1'b0);

`ifdef BRANCH_SEQ_STATS_EN
        check("stat_taken", stat_taken, 16'(m_cnt_t));
        check("stat_not_taken", stat_not_taken, 16'(m_cnt_nt));
`endif

        // reset while waiting on the branch unit
        br(1'b1, 1'b0, 3'd0, 32'd1, 32'd1, 10'd70, 1'b1, 10'd400);
        idle(1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 20'd0, 32'd0, 32'd0, 10'd0, 1'b1, 10'd400);
        repeat (3) idle(1'b0);

        for (int i = 0; i < 3000; i++) begin
            cls = 2'($urandom_range(0, 3));
            step(1'b1, ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1), cls[0], cls[1],
                 3'($urandom), 20'($urandom), $urandom, $urandom, 10'($urandom),
                 ($urandom_range(0, 1) == 1), 10'($urandom));
        end
        repeat (12) idle(1'b0);

        check("iss_queue_empty", 64'(exp_iss.size()), 64'd0);
        check("res_queue_empty", 64'(exp_res.size()), 64'd0);
`ifdef BRANCH_SEQ_STATS_EN
        check("stat_taken_end", stat_taken, 16'(m_cnt_t));
        check("stat_not_taken_end", stat_not_taken, 16'(m_cnt_nt));
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Sequencer that owns the 10-bit fetch PC and drives the branch unit through its edge-triggered enable. It accepts decoded branch/jump instructions and issues a single `bu_en` pulse per instruction. It waits for the unit's latched result, then either resumes sequential fetch or redirects the PC and flushes the wrong-path instructions. It sits between decode and fetch; the branch unit is its only resource.

## Interface
- `ADDR_W`, 10, PC and target width; must match the branch unit's address width
- `RESET_PC`, 10'd0, PC value loaded on reset
- `FLUSH_CYCLES`, 2, cycles `flush` stays high after a taken redirect (1..7)
- `clk`  in  1  sole clock; all state updates on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `stall`  in  1  freezes PC increment and instruction acceptance in RUN
- `insn_valid`  in  1  decoded instruction present this cycle
- `is_branch`, `is_jump`  in  1 each  decoded class; both high is treated as jump
- `funct3`  in  3  branch condition code
- `imm`  in  20  branch/jump offset
- `op0`, `op1`  in  32 each  register operands
- `insn_pc`  in  ADDR_W  address of the decoded instruction
- `bu_branch`  in  1  branch unit taken result
- `bu_target`  in  ADDR_W  branch unit target address
- `bu_en`  out  1  enable to branch unit; rising edge latches
- `bu_b`, `bu_j`  out  1 each  class to branch unit
- `bu_funct3`, `bu_imm`, `bu_op0`, `bu_op1`, `bu_addr`  out  3/20/32/32/ADDR_W  registered operands to branch unit
- `pc`  out  ADDR_W  fetch address
- `busy`  out  1  branch in flight; decode must hold
- `flush`  out  1  kill fetched/decoded wrong-path instructions
- `redirect`  out  1  one-cycle pulse when `pc` loaded from target

## Operation
- States: RUN, ISSUE, WAIT, RESOLVE, FLUSH.
- Reset (`rst_n`=0 at edge): state RUN, `pc`=RESET_PC, all other outputs and `bu_*` registers 0, flush counter 0.
- RUN, `stall`=0, no branch accepted: `pc`<=`pc`+1, wrapping 1023→0.
- RUN, `stall`=1: `pc` holds, nothing accepted.
- Accept condition: RUN, `stall`=0, `insn_valid`=1, and `is_branch` or `is_jump`.
- On accept:
  - capture operands into `bu_*` (`bu_addr`<=`insn_pc`, `bu_j`<=`is_jump`, `bu_b`<=`is_branch & ~is_jump`);
  - `pc` holds; → ISSUE.
- ISSUE: `bu_en`=1, `busy`=1; → WAIT.
- WAIT: `bu_en`=0, `busy`=1; the branch unit result settles; → RESOLVE.
- RESOLVE: sample `bu_branch`, `busy`=1.
  - Taken: `pc`<=`bu_target`, `redirect`=1 next cycle, `flush`=1, counter<=FLUSH_CYCLES-1; → FLUSH.
  - Not taken: `pc`<=`bu_addr`+1 (wraps); → RUN.
- FLUSH: `flush`=1, `busy`=0, `pc` increments unless `stall`. Each cycle the counter decrements; at 0 → RUN. `insn_valid` is ignored, so no accept occurs.
- `bu_*` operand registers hold from accept until the next accept; they are stable across ISSUE..RESOLVE.
- `stall` is ignored in ISSUE, WAIT and RESOLVE.
- `rst_n` low in any state forces reset values at that edge. `bu_en` drops without completing, and no redirect occurs.

## Timing
- Accept at edge N. `bu_en` is high N..N+1. RESOLVE is N+2..N+3. New `pc` is visible after edge N+3.
- Branch latency is 3 cycles with `busy` high. A taken branch adds FLUSH_CYCLES cycles of `flush`.
- `bu_en` is high exactly one cycle per accepted instruction and is never high in two consecutive cycles.
- `redirect` is high exactly the first cycle `pc` shows `bu_target`, coincident with the first `flush` cycle.
- Back-to-back branches: the second can be accepted at the earliest in the first RUN cycle after RESOLVE (not taken) or after FLUSH (taken).

## Configuration
- Macro `BRANCH_SEQ_STATS_EN`.
- Defined: adds outputs `stat_taken` and `stat_not_taken`, 16 bits each. They increment in RESOLVE, saturate at 16'hFFFF, and are cleared by reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset with RESET_PC=10'd5, hold 3 cycles with `stall`=0 → `pc` = 5,6,7,8; `bu_en`, `flush`, `busy` = 0.
- BEQ `op0`=`op1`=32'h1234, `insn_pc`=10'd20, stub target 10'd40, `bu_branch`=1:
  - `bu_en` is pulsed once;
  - `busy` is high 3 cycles;
  - `pc`=40 with `redirect`=1;
  - `flush` is high 2 cycles.
- BNE with equal operands, `insn_pc`=10'd20, `bu_branch`=0 → `pc`=21 after RESOLVE; `flush` and `redirect` never asserted.
- Wrap: PC runs 1022→1023→0. Not-taken branch at `insn_pc`=1023 → `pc`=0.
- `insn_valid` branch during FLUSH and during `stall`=1 → no `bu_en` pulse, no state change. `rst_n`=0 in WAIT → `pc`=RESET_PC, `busy`=0 next cycle.
- With `BRANCH_SEQ_STATS_EN` defined: 3 taken and 2 not-taken branches → `stat_taken`=3, `stat_not_taken`=2.
